gouram_trace_serialiser: RTL and testbench

- Sits directly downstream of the gouram trace generator.
- Captures each 128-bit trace record into a small FIFO and drains it as a stream of 32-bit words over a valid/ready handshake, toward a debug/host link.
- Isolates the processor-side trace producer from back-pressure on the link.
- Counts records lost when the FIFO is full.

---
 rtl/gouram_trace_serialiser.sv | 145 ++++++++++++++
 tb/tb_gouram_trace_serialiser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gouram_trace_serialiser.sv
// Buffers 128-bit gouram trace records in a small FIFO and streams each one out
// as OUT_WIDTH-bit words, least-significant first, over a valid/ready link.
module gouram_trace_serialiser #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trace_valid_i,
    input  logic [IN_WIDTH-1:0]        trace_data_i,
    input  logic                       clear_i,
    output logic                       m_valid_o,
    output logic [OUT_WIDTH-1:0]       m_data_o,
    output logic                       m_last_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       overflow_o,
    output logic [CNT_WIDTH-1:0]       drop_count_o
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic [BW-1:0]        LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                          state_r;
    logic [IN_WIDTH-1:0]             mem_r [DEPTH];
    logic [AW-1:0]                   wptr_r;
    logic [AW-1:0]                   rptr_r;
    logic [LW-1:0]                   level_r;
    logic [BW-1:0]                   beat_r;
    logic                            valid_r;
    logic                            overflow_r;
    logic [CNT_WIDTH-1:0]            drop_r;

    logic [BEATS-1:0][OUT_WIDTH-1:0] head_s;
    logic                            last_s;
    logic                            hs_s;
    logic                            pop_s;
    logic                            full_s;
    logic                            push_s;
    logic                            drop_s;

    // Handshake decode; a full FIFO still accepts a record if the head leaves this cycle.
    always_comb begin
        head_s = mem_r[rptr_r];
        last_s = valid_r & (beat_r == LAST_BEAT);
        hs_s   = valid_r & m_ready_i;
        pop_s  = hs_s & last_s;
        full_s = (level_r == FULL_LEVEL);
        push_s = trace_valid_i & (~full_s | pop_s);
        drop_s = trace_valid_i & full_s & ~pop_s;
    end

    // Record storage; a flushed cycle never writes.
    always_ff @(posedge clk) begin
        if (rst_n && !clear_i && push_s) begin
            mem_r[wptr_r] <= trace_data_i;
        end
    end

    // Pointers, level, drop status and the beat-streaming FSM.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            beat_r     <= {BW{1'b0}};
            overflow_r <= 1'b0;
            drop_r     <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end

            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase

            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != CNT_MAX) begin
                    drop_r <= drop_r + CNT_WIDTH'(1);
                end
            end

            case (state_r)
                IDLE: begin
                    if (level_r != LW'(0)) begin
                        state_r <= STREAM;
                        valid_r <= 1'b1;
                    end
                end
                STREAM: begin
                    if (hs_s) begin
                        if (last_s) begin
                            beat_r <= {BW{1'b0}};
                            // Keep streaming without a bubble when another record is ready.
                            if ((level_r > LW'(1)) || push_s) begin
                                state_r <= STREAM;
                                valid_r <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                valid_r <= 1'b0;
                            end
                        end else begin
                            beat_r <= beat_r + BW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    beat_r  <= {BW{1'b0}};
                end
            endcase
        end
    end

    assign m_valid_o    = valid_r;
    assign m_last_o     = last_s;
    assign m_data_o     = valid_r ? head_s[beat_r] : {OUT_WIDTH{1'b0}};
    assign fifo_level_o = level_r;
    assign overflow_o   = overflow_r;
    assign drop_count_o = drop_r;

endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// Bench for gouram_trace_serialiser: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_gouram_trace_serialiser;

    localparam int DEPTH = 16;
    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         trace_valid;
    logic [127:0] trace_data;
    logic         clear;
    logic         m_ready;

    logic         m_valid, s_valid;
    logic [31:0]  m_data, s_data;
    logic         m_last, s_last;
    logic [4:0]   level, s_level;
    logic         ovf, s_ovf;
    logic [15:0]  drops;
    logic [1:0]   s_drops;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // reference model state
    logic [127:0] mq[$];
    bit           mvalid = 1'b0;
    int           mbeat  = 0;
    bit           movf   = 1'b0;
    int           mdrops = 0;

    logic [31:0]  cap_d[$];
    bit           cap_l[$];

    always #5 clk = ~clk;

    gouram_trace_serialiser u_dut (
        .clk(clk), .rst_n(rst_n), .trace_valid_i(trace_valid), .trace_data_i(trace_data),
        .clear_i(clear), .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last),
        .m_ready_i(m_ready), .fifo_level_o(level), .overflow_o(ovf), .drop_count_o(drops)
    );

    gouram_trace_serialiser #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .trace_valid_i(trace_valid), .trace_data_i(trace_data),
        .clear_i(clear), .m_valid_o(s_valid), .m_data_o(s_data), .m_last_o(s_last),
        .m_ready_i(m_ready), .fifo_level_o(s_level), .overflow_o(s_ovf), .drop_count_o(s_drops)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rec(input int k);
        rec = {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
    endfunction

    // Model: records queued, one word per accepted handshake, registered valid.
    initial forever begin
        bit hs, pop, push, drop;
        int sz;
        @(posedge clk);
        if (!rst_n || clear) begin
            mq.delete();
            mvalid = 1'b0; mbeat = 0; movf = 1'b0; mdrops = 0;
        end else begin
            sz   = mq.size();
            hs   = mvalid && m_ready;
            pop  = hs && (mbeat == BEATS-1);
            push = trace_valid && (sz < DEPTH || pop);
            drop = trace_valid && !push;
            if (!mvalid) mvalid = (sz > 0);
            else if (pop) mvalid = (sz > 1) || push;
            if (hs) mbeat = pop ? 0 : mbeat + 1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(trace_data);
            if (drop) begin
                movf = 1'b1;
                if (mdrops < 65535) mdrops++;
            end
        end
    end

    // Compare process: model vs both DUTs, stall stability, word capture.
    initial forever begin
        logic [127:0] head;
        logic [31:0]  exp_data;
        bit           exp_last;
        bit           prev_stall = 1'b0;
        logic [31:0]  prev_data  = 32'h0;
        bit           prev_last  = 1'b0;
        @(negedge clk);
        if (chk_en) begin
            exp_data = 32'h0;
            if (mvalid && mq.size() > 0) begin
                head     = mq[0];
                exp_data = head[mbeat*32 +: 32];
            end
            exp_last = mvalid && (mbeat == BEATS-1);
            chk("valid", 32'(m_valid), 32'(mvalid));
            chk("data",  m_data, exp_data);
            chk("last",  32'(m_last), 32'(exp_last));
            chk("level", 32'(level), 32'(mq.size()));
            chk("ovf",   32'(ovf), 32'(movf));
            chk("drops", 32'(drops), 32'(mdrops));
            chk("sat_valid", 32'(s_valid), 32'(mvalid));
            chk("sat_data",  s_data, exp_data);
            chk("sat_last",  32'(s_last), 32'(exp_last));
            chk("sat_level", 32'(s_level), 32'(mq.size()));
            chk("sat_drops", 32'(s_drops), 32'((mdrops > 3) ? 3 : mdrops));
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data",  m_data, prev_data);
                chk("stall_last",  32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready && rst_n && !clear) begin
                cap_d.push_back(m_data);
                cap_l.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready && rst_n && !clear;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; trace_valid = 1'b0; trace_data = 128'h0; m_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  m_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drops", 32'(drops), 32'd0);

        // single record, two-cycle latency, LSW first
        m_ready = 1'b1; trace_valid = 1'b1;
        trace_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        tick();
        trace_valid = 1'b0;
        chk("t1_lvl_after_push", 32'(level), 32'd1);
        chk("t1_valid_early", 32'(m_valid), 32'd0);
        tick();
        chk("t1_valid_rise", 32'(m_valid), 32'd1);
        chk("t1_w0", m_data, 32'h1111_1111);
        chk("t1_last0", 32'(m_last), 32'd0);
        tick(); chk("t1_w1", m_data, 32'h2222_2222);
        tick(); chk("t1_w2", m_data, 32'h3333_3333);
        tick(); chk("t1_w3", m_data, 32'h4444_4444);
        chk("t1_last3", 32'(m_last), 32'd1);
        tick();
        chk("t1_idle", 32'(m_valid), 32'd0);
        chk("t1_lvl0", 32'(level), 32'd0);

        // 20 records into a 16-deep FIFO with the link stalled
        m_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            trace_valid = 1'b1; trace_data = rec(k); tick();
        end
        trace_valid = 1'b0;
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_ovf", 32'(ovf), 32'd1);
        chk("t2_drops", 32'(drops), 32'd4);
        chk("t2_sat_drops", 32'(s_drops), 32'd3);
        cap_d.delete(); cap_l.delete();
        m_ready = 1'b1;
        for (int t = 0; t < 70; t++) tick();
        chk("t2_count", 32'(cap_d.size()), 32'd64);
        for (int i = 0; i < cap_d.size(); i++) chk("t2_word", cap_d[i], 32'(i));
        chk("t2_lvl0", 32'(level), 32'd0);

        // full FIFO: push coincides with final-beat pop
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_clr_drops", 32'(drops), 32'd0);
        chk("t3_clr_ovf", 32'(ovf), 32'd0);
        m_ready = 1'b0;
        for (int k = 32; k < 48; k++) begin
            trace_valid = 1'b1; trace_data = rec(k); tick();
        end
        trace_valid = 1'b0;
        chk("t3_full", 32'(level), 32'd16);
        cap_d.delete(); cap_l.delete();
        m_ready = 1'b1;
        tick(); tick(); tick();
        trace_valid = 1'b1; trace_data = rec(48);
        tick();
        trace_valid = 1'b0;
        chk("t3_level_held", 32'(level), 32'd16);
        chk("t3_no_drop", 32'(drops), 32'd0);
        for (int t = 0; t < 70; t++) tick();
        chk("t3_count", 32'(cap_d.size()), 32'd68);
        for (int i = 0; i < cap_d.size(); i++) chk("t3_word", cap_d[i], 32'(128 + i));

        // random back-pressure over three records
        clear = 1'b1; tick(); clear = 1'b0;
        cap_d.delete(); cap_l.delete();
        m_ready = 1'b0;
        for (int k = 60; k < 63; k++) begin
            trace_valid = 1'b1; trace_data = rec(k); tick();
        end
        trace_valid = 1'b0;
        tick();
        for (int t = 0; t < 300 && cap_d.size() < 12; t++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b0;
        chk("t4_count", 32'(cap_d.size()), 32'd12);
        for (int i = 0; i < cap_d.size(); i++) begin
            chk("t4_word", cap_d[i], 32'(240 + i));
            chk("t4_last", 32'(cap_l[i]), 32'((i % 4) == 3));
        end

        // clear mid-record with a simultaneous push
        clear = 1'b1; tick(); clear = 1'b0;
        trace_valid = 1'b1; trace_data = rec(70); tick();
        trace_valid = 1'b0;
        tick();
        chk("t5_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        tick(); tick();
        clear = 1'b1; trace_valid = 1'b1; trace_data = rec(71);
        tick();
        clear = 1'b0; trace_valid = 1'b0;
        chk("t5_valid_clr", 32'(m_valid), 32'd0);
        chk("t5_level_clr", 32'(level), 32'd0);
        chk("t5_drops_clr", 32'(drops), 32'd0);
        cap_d.delete(); cap_l.delete();
        trace_valid = 1'b1; trace_data = rec(72); tick();
        trace_valid = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        chk("t5_count", 32'(cap_d.size()), 32'd4);
        for (int i = 0; i < cap_d.size(); i++) chk("t5_word", cap_d[i], 32'(288 + i));

        // counter saturation, then reset mid-transfer
        clear = 1'b1; tick(); clear = 1'b0;
        m_ready = 1'b0;
        for (int k = 80; k < 102; k++) begin
            trace_valid = 1'b1; trace_data = rec(k); tick();
        end
        trace_valid = 1'b0;
        chk("t6_drops", 32'(drops), 32'd6);
        chk("t6_sat", 32'(s_drops), 32'd3);
        chk("t6_sat_ovf", 32'(s_ovf), 32'd1);
        m_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", m_data, 32'd0);
        chk("t6_rst_last", 32'(m_last), 32'd0);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ovf", 32'(ovf), 32'd0);
        chk("t6_rst_drops", 32'(drops), 32'd0);
        chk("t6_rst_sat", 32'(s_drops), 32'd0);
        for (int t = 0; t < 4; t++) tick();
        chk("t6_quiet", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
